puf_response_controller: RTL and testbench
==========================================

# puf_response_controller

Sequencer for the ring-oscillator PUF measurement datapath. For each bit of an N_BITS response, it takes a pair of RO indices from the challenge and drives them onto the mux selects. It then clears the edge counters, opens a fixed counting window, waits for the counts to settle, and compares the two counts into one response bit. It sits between the host/challenge interface and the RO mux + counter pair, and owns every control signal of that datapath.

## Interface
- SEL_W, 3: width of one RO index (up to 2^SEL_W oscillators).
- N_BITS, 8: response bits per challenge.
- COUNT_W, 16: counter width, matching the edge counters.
- WINDOW, 1024: counting-window length in clk cycles (≥1).
- SYNC_CYC, 2: settle cycles after the window closes, before compare (≥0).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new response; sampled only in IDLE.
- challenge  in  N_BITS*2*SEL_W  slice i = bits [(i+1)*2*SEL_W-1 : i*2*SEL_W]; upper SEL_W = RO A, lower SEL_W = RO B.
- count_a, count_b  in  COUNT_W  counter values for RO A and RO B.
- sel_a, sel_b  out  SEL_W  mux selects; registered.
- cnt_rst  out  1  counter clear; registered.
- cnt_en  out  1  counting-window gate to the mux path; registered.
- busy  out  1  high from start acceptance through DONE.
- done  out  1  one-cycle pulse; response is complete.
- response  out  N_BITS  bit i is the result for challenge slice i.
- flag  out  N_BITS  bit i set if slice i was a tie, same-RO pair, or saturated count.

## Operation
- Reset values: state IDLE, sel_a=sel_b=0, cnt_rst=1, cnt_en=0, busy=0, done=0, response=0, flag=0, bit index=0, timer=0.
- IDLE:
  - cnt_rst=1 and busy=0.
  - If start=1, latch challenge, clear response and flag, set idx=0, and go to SELECT.
- SELECT (1 cycle):
  - Load sel_a/sel_b from slice idx; cnt_rst=1.
  - If A==B, skip measurement and go to COMPARE with forced result. Otherwise go to MEASURE.
- MEASURE (WINDOW cycles):
  - cnt_rst=0, cnt_en=1; timer counts 0..WINDOW-1.
  - At the last count, go to HOLD (or to COMPARE if SYNC_CYC=0).
- HOLD (SYNC_CYC cycles): cnt_en=0, cnt_rst=0; selects unchanged.
- COMPARE (1 cycle):
  - response[idx] = (count_a > count_b).
  - flag[idx] = (count_a == count_b) OR (A==B) OR (count_a all-ones) OR (count_b all-ones).
  - A==B forces response[idx]=0.
  - If idx==N_BITS-1, go to DONE; else idx++ and go to SELECT.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- response and flag hold until the next start is accepted.
- Comparison is unsigned and full COUNT_W width. The timer width is ceil(log2(WINDOW+1)).
- start while busy is ignored; there is no queueing.
- Reset in any state returns to IDLE on the next edge with the reset values above; counters are re-cleared through cnt_rst=1.
- challenge changes after acceptance have no effect.

## Timing
- Start accepted at edge 0 means SELECT occupies cycle 1.
- Non-degenerate bit period is P = WINDOW + SYNC_CYC + 2 cycles; a same-RO bit takes 2 cycles.
- The last COMPARE occurs at cycle N_BITS*P; done is high in cycle N_BITS*P+1.
- busy falls in the cycle after done.
- response[idx] is visible in the cycle following its COMPARE.
- cnt_en is high for exactly WINDOW cycles per bit and never overlaps cnt_rst=1.
- sel_a/sel_b are stable from SELECT through COMPARE.

## Structure
- Package puf_pkg:
  - state enum (IDLE, SELECT, MEASURE, HOLD, COMPARE, DONE);
  - default SEL_W, COUNT_W, WINDOW, SYNC_CYC constants;
  - a challenge-slice extraction function.
- Sub-module puf_window_timer: loadable down-counter with a terminal-count output, reused for the MEASURE and HOLD phases.
- The FSM, index register, and compare logic live in the top level.

## Test plan
Bench parameters: N_BITS=4, SEL_W=3, WINDOW=16, SYNC_CYC=2 (P=20).
- Reset, then idle 10 cycles: cnt_rst=1, cnt_en=0, busy=0, response=0, flag=0 throughout.
- Challenge 0x?(A=5,B=2 on every slice), model count_a=40, count_b=31: done at cycle 81, response=4'b1111, flag=0, cnt_en high 16 cycles per bit.
- Slice 2 with A==B=3: that bit takes 2 cycles, response[2]=0, flag[2]=1, done at cycle 63.
- Equal counts 25/25 on slice 0, and count_a=16'hFFFF on slice 1: flag=4'b0011, response[0]=0, response[1]=1.
- start pulsed at cycles 5 and 40 during a run: ignored, single done pulse; a new start one cycle after done is accepted.
- rst asserted at cycle 30 (MEASURE of bit 1): next cycle state IDLE, cnt_en=0, cnt_rst=1, busy=0, response=0; a subsequent start completes normally.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF response controller.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        MEASURE,
        HOLD,
        COMPARE,
        DONE
    } puf_state_t;

    localparam int SEL_W_DEF    = 3;
    localparam int N_BITS_DEF   = 8;
    localparam int COUNT_W_DEF  = 16;
    localparam int WINDOW_DEF   = 1024;
    localparam int SYNC_CYC_DEF = 2;
    localparam int CHAL_MAX_W   = 256;

    // Brings challenge slice idx down to the LSBs; caller keeps the low 2*sel_w bits.
    function automatic logic [CHAL_MAX_W-1:0] chal_slice(input logic [CHAL_MAX_W-1:0] chal,
                                                         input int idx,
                                                         input int sel_w);
        return chal >> (idx * 2 * sel_w);
    endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter with terminal count; times both the counting window and the settle gap.
module puf_window_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/puf_response_controller.sv
// Sequences RO pair selection, counter clear, counting window, settle and compare for each response bit.
module puf_response_controller
    import puf_pkg::*;
#(
    parameter int SEL_W    = SEL_W_DEF,
    parameter int N_BITS   = N_BITS_DEF,
    parameter int COUNT_W  = COUNT_W_DEF,
    parameter int WINDOW   = WINDOW_DEF,
    parameter int SYNC_CYC = SYNC_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_BITS*2*SEL_W-1:0] challenge,
    input  logic [COUNT_W-1:0]        count_a,
    input  logic [COUNT_W-1:0]        count_b,
    output logic [SEL_W-1:0]          sel_a,
    output logic [SEL_W-1:0]          sel_b,
    output logic                      cnt_rst,
    output logic                      cnt_en,
    output logic                      busy,
    output logic                      done,
    output logic [N_BITS-1:0]         response,
    output logic [N_BITS-1:0]         flag
);

    localparam int CHAL_W    = N_BITS * 2 * SEL_W;
    localparam int IDX_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int TMR_W     = $clog2(((WINDOW > SYNC_CYC) ? WINDOW : SYNC_CYC) + 1);
    localparam int HOLD_LOAD = (SYNC_CYC > 0) ? SYNC_CYC - 1 : 0;

    function automatic logic is_sat(input logic [COUNT_W-1:0] c);
        return &c;
    endfunction

    puf_state_t          state, state_n;
    logic [CHAL_W-1:0]   chal_q, chal_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [N_BITS-1:0]   resp_n, flag_n;
    logic [2*SEL_W-1:0]  pair_n;
    logic                tmr_load, tmr_tc, same;
    logic [TMR_W-1:0]    tmr_val;

    assign same   = (sel_a == sel_b);
    assign pair_n = (2*SEL_W)'(chal_slice(CHAL_MAX_W'(chal_n), int'(idx_n), SEL_W));

    puf_window_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_n  = state;
        chal_n   = chal_q;
        idx_n    = idx;
        resp_n   = response;
        flag_n   = flag;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    chal_n  = challenge;
                    idx_n   = '0;
                    resp_n  = '0;
                    flag_n  = '0;
                    state_n = SELECT;
                end
            end
            SELECT: begin
                if (same) begin
                    state_n = COMPARE;
                end else begin
                    state_n  = MEASURE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(WINDOW - 1);
                end
            end
            MEASURE: begin
                if (tmr_tc) begin
                    if (SYNC_CYC == 0) begin
                        state_n = COMPARE;
                    end else begin
                        state_n  = HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(HOLD_LOAD);
                    end
                end
            end
            HOLD: begin
                if (tmr_tc) state_n = COMPARE;
            end
            COMPARE: begin
                // A same-RO pair never measured anything, so its bit is forced low and flagged.
                resp_n[idx] = !same && (count_a > count_b);
                flag_n[idx] = same || (count_a == count_b) || is_sat(count_a) || is_sat(count_b);
                if (idx == IDX_W'(N_BITS - 1)) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = SELECT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            chal_q   <= '0;
            idx      <= '0;
            sel_a    <= '0;
            sel_b    <= '0;
            cnt_rst  <= 1'b1;
            cnt_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
            flag     <= '0;
        end else begin
            state    <= state_n;
            chal_q   <= chal_n;
            idx      <= idx_n;
            response <= resp_n;
            flag     <= flag_n;
            cnt_rst  <= (state_n == IDLE) || (state_n == SELECT) || (state_n == DONE);
            cnt_en   <= (state_n == MEASURE);
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE);
            if (state_n == SELECT) begin
                sel_a <= pair_n[2*SEL_W-1:SEL_W];
                sel_b <= pair_n[SEL_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_puf_response_controller.sv
// Directed-vector bench for puf_response_controller with a per-RO static count model.
module tb_puf_response_controller;

    localparam int SEL_W    = 3;
    localparam int N_BITS   = 4;
    localparam int COUNT_W  = 16;
    localparam int WINDOW   = 16;
    localparam int SYNC_CYC = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [N_BITS*2*SEL_W-1:0] challenge;
    logic [COUNT_W-1:0]        count_a, count_b;
    logic [SEL_W-1:0]          sel_a, sel_b;
    logic                      cnt_rst, cnt_en, busy, done;
    logic [N_BITS-1:0]         response, flag;

    logic [COUNT_W-1:0] ro_cnt [8];

    int checks = 0;
    int errors = 0;

    assign count_a = ro_cnt[sel_a];
    assign count_b = ro_cnt[sel_b];

    always #5 clk = ~clk;

    puf_response_controller #(
        .SEL_W(SEL_W), .N_BITS(N_BITS), .COUNT_W(COUNT_W), .WINDOW(WINDOW), .SYNC_CYC(SYNC_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .count_a(count_a), .count_b(count_b), .sel_a(sel_a), .sel_b(sel_b),
        .cnt_rst(cnt_rst), .cnt_en(cnt_en), .busy(busy), .done(done),
        .response(response), .flag(flag)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; challenge = '0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({sel_a, sel_b, cnt_rst, cnt_en, busy, done, response, flag} !== {6'd0, 1'b1, 3'b000, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: got %0h expected %0h",
                     {sel_a, sel_b, cnt_rst, cnt_en, busy, done, response, flag}, {6'd0, 1'b1, 3'b000, 8'h00});
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({cnt_rst, cnt_en, busy, done, response, flag} !== {1'b1, 3'b000, 8'h00}) begin
                errors++;
                $display("FAIL idle_cycle%0d: got %0h expected %0h", i,
                         {cnt_rst, cnt_en, busy, done, response, flag}, {1'b1, 3'b000, 8'h00});
            end
        end
    endtask

    // Entered and left at #1 after an edge with the DUT idle; returns in the cycle after done.
    task automatic run_check(input string name, input logic [23:0] chal, input int p1, input int p2,
                             input int exp_done, input logic [3:0] exp_resp, input logic [3:0] exp_flag,
                             input int exp_en);
        int done_cyc, done_cnt, en_cnt, overlap;
        logic busy_at_done, busy_after;
        logic [2:0] sa, sb;
        logic [23:0] c;
        c = chal; done_cyc = -1; done_cnt = 0; en_cnt = 0; overlap = 0; busy_at_done = 1'b0;
        start = 1'b1; challenge = chal;
        @(posedge clk); #1;
        challenge = ~chal;
        sa = sel_a; sb = sel_b;
        for (int n = 1; n <= exp_done + 1; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            start = (n == p1) || (n == p2);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (cnt_en) en_cnt++;
            if (cnt_en && cnt_rst) overlap++;
            if (n == exp_done) busy_at_done = busy;
        end
        start = 1'b0;
        busy_after = busy;
        chk({name, "_sel_a"}, 32'(sa), 32'(c[5:3]));
        chk({name, "_sel_b"}, 32'(sb), 32'(c[2:0]));
        chk({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({name, "_response"}, 32'(response), 32'(exp_resp));
        chk({name, "_flag"}, 32'(flag), 32'(exp_flag));
        chk({name, "_cnt_en_cycles"}, 32'(en_cnt), 32'(exp_en));
        chk({name, "_en_rst_overlap"}, 32'(overlap), 32'd0);
        chk({name, "_busy_at_done"}, 32'(busy_at_done), 32'd1);
        chk({name, "_busy_after"}, 32'(busy_after), 32'd0);
    endtask

    task automatic test_all_greater();
        ro_cnt[5] = 16'd40; ro_cnt[2] = 16'd31;
        run_check("greater", {3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2}, -1, -1, 81, 4'b1111, 4'b0000, 64);
    endtask

    task automatic test_same_ro();
        ro_cnt[5] = 16'd40; ro_cnt[2] = 16'd31; ro_cnt[3] = 16'd77;
        run_check("same_ro", {3'd5, 3'd2, 3'd3, 3'd3, 3'd5, 3'd2, 3'd5, 3'd2}, -1, -1, 63, 4'b1011, 4'b0100, 48);
    endtask

    task automatic test_ties_saturation();
        ro_cnt[5] = 16'd40; ro_cnt[2] = 16'd31;
        ro_cnt[1] = 16'd25; ro_cnt[4] = 16'd25;
        ro_cnt[7] = 16'hFFFF; ro_cnt[6] = 16'd100;
        run_check("tie_sat", {3'd5, 3'd2, 3'd5, 3'd2, 3'd7, 3'd6, 3'd1, 3'd4}, -1, -1, 81, 4'b1110, 4'b0011, 64);
    endtask

    task automatic test_back_to_back();
        ro_cnt[5] = 16'd40; ro_cnt[2] = 16'd31; ro_cnt[3] = 16'd77;
        run_check("start_ignored", {3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2}, 5, 40, 81, 4'b1111, 4'b0000, 64);
        run_check("restart", {3'd5, 3'd2, 3'd3, 3'd3, 3'd5, 3'd2, 3'd5, 3'd2}, -1, -1, 63, 4'b1011, 4'b0100, 48);
    endtask

    task automatic test_reset_midrun();
        ro_cnt[5] = 16'd40; ro_cnt[2] = 16'd31;
        start = 1'b1; challenge = {4{3'd5, 3'd2}};
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 2; n <= 30; n++) begin @(posedge clk); #1; end
        chk("midrun_busy_before", 32'(busy), 32'd1);
        chk("midrun_cnt_en_before", 32'(cnt_en), 32'd1);
        chk("midrun_resp_before", 32'(response), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_cnt_en", 32'(cnt_en), 32'd0);
        chk("midrun_cnt_rst", 32'(cnt_rst), 32'd1);
        chk("midrun_busy", 32'(busy), 32'd0);
        chk("midrun_response", 32'(response), 32'd0);
        chk("midrun_done", 32'(done), 32'd0);
        run_check("after_reset", {4{3'd5, 3'd2}}, -1, -1, 81, 4'b1111, 4'b0000, 64);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ro_cnt[i] = '0;
        test_reset();
        test_all_greater();
        test_same_ro();
        test_ties_saturation();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
